pwm_deadtime_gen: RTL and testbench

Complementary-output dead-time stage sitting directly downstream of the PWM counter/compare channels. It takes one raw PWM level per channel and drives the A/B gate pair on the chip's dedicated outputs, with both sides low for a programmable dead-time between every hand-over. It also provides a synchronous fault shutdown with a sticky flag and a per-channel enable. The peripheral register file owns the dead-time, enable and fault-clear values; this block only consumes them.

---
 rtl/pwm_deadtime_gen_if.sv | 26 ++
 rtl/pwm_deadtime_gen.sv | 109 ++++++++++
 tb/tb_pwm_deadtime_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadtime_gen_if.sv
// Bundle of the dead-time stage signals: raw PWM levels and controls in, gate pairs out.
// master drives the controls; slave is the dead-time generator.
interface pwm_deadtime_gen_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DT_WIDTH = 8
);
  logic [CHANNELS-1:0]          pwm;
  logic [CHANNELS-1:0]          enable;
  logic [CHANNELS*DT_WIDTH-1:0] deadtime;
  logic                         fault;
  logic                         fault_clr;
  logic [CHANNELS-1:0]          pwm_a;
  logic [CHANNELS-1:0]          pwm_b;
  logic [CHANNELS-1:0]          dt_active;
  logic                         fault_flag;

  modport master (
    output pwm, enable, deadtime, fault, fault_clr,
    input  pwm_a, pwm_b, dt_active, fault_flag
  );

  modport slave (
    input  pwm, enable, deadtime, fault, fault_clr,
    output pwm_a, pwm_b, dt_active, fault_flag
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary A/B gate driver with a programmable all-off gap on every hand-over,
// per-channel enable and a sticky synchronous fault shutdown.
module pwm_deadtime_gen #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned DT_WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  pwm_deadtime_gen_if.slave bus
);
  typedef enum logic [2:0] {StOff, StAOn, StDtToB, StBOn, StDtToA} state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [DT_WIDTH-1:0] cnt_q   [CHANNELS];
  logic [DT_WIDTH-1:0] cnt_d   [CHANNELS];
  logic [DT_WIDTH-1:0] dt_val  [CHANNELS];
  logic [CHANNELS-1:0] pwm_r_q;
  logic [CHANNELS-1:0] blk;
  logic [CHANNELS-1:0] go_dt;
  logic [CHANNELS-1:0] pwm_a_q;
  logic [CHANNELS-1:0] pwm_b_q;
  logic [CHANNELS-1:0] dt_active_q;
  logic                fault_q;

  // Raw fault joins the sticky flag so outputs drop on the same edge the flag sets.
  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    assign dt_val[n] = bus.deadtime[n*DT_WIDTH +: DT_WIDTH];
    assign blk[n]    = fault_q | bus.fault | ~bus.enable[n];
  end

  always_comb begin
    go_dt = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      if (blk[n]) begin
        state_d[n] = StOff;
        cnt_d[n]   = '0;
      end else begin
        unique case (state_q[n])
          StOff:   go_dt[n] = 1'b1;
          StAOn:   go_dt[n] = ~pwm_r_q[n];
          StBOn:   go_dt[n] = pwm_r_q[n];
          StDtToB: begin
            if (pwm_r_q[n]) begin
              state_d[n] = StAOn;
              cnt_d[n]   = '0;
            end else if (cnt_q[n] == '0) begin
              state_d[n] = StBOn;
            end else begin
              cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
            end
          end
          StDtToA: begin
            if (!pwm_r_q[n]) begin
              state_d[n] = StBOn;
              cnt_d[n]   = '0;
            end else if (cnt_q[n] == '0) begin
              state_d[n] = StAOn;
            end else begin
              cnt_d[n] = cnt_q[n] - DT_WIDTH'(1);
            end
          end
          default: state_d[n] = StOff;
        endcase
        // A zero dead-time skips the gap state entirely.
        if (go_dt[n]) begin
          if (dt_val[n] == '0) begin
            state_d[n] = pwm_r_q[n] ? StAOn : StBOn;
            cnt_d[n]   = '0;
          end else begin
            state_d[n] = pwm_r_q[n] ? StDtToA : StDtToB;
            cnt_d[n]   = dt_val[n] - DT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_r_q     <= '0;
      fault_q     <= 1'b0;
      pwm_a_q     <= '0;
      pwm_b_q     <= '0;
      dt_active_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n] <= StOff;
        cnt_q[n]   <= '0;
      end
    end else begin
      pwm_r_q <= bus.pwm;
      fault_q <= bus.fault | (fault_q & ~bus.fault_clr);
      for (int n = 0; n < CHANNELS; n++) begin
        state_q[n]     <= state_d[n];
        cnt_q[n]       <= cnt_d[n];
        pwm_a_q[n]     <= (state_d[n] == StAOn);
        pwm_b_q[n]     <= (state_d[n] == StBOn);
        dt_active_q[n] <= (state_d[n] == StDtToB) || (state_d[n] == StDtToA);
      end
    end
  end

  assign bus.pwm_a      = pwm_a_q;
  assign bus.pwm_b      = pwm_b_q;
  assign bus.dt_active  = dt_active_q;
  assign bus.fault_flag = fault_q;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: directed scenarios then random traffic, every cycle compared
// against a side/gap model of the gate pair.
module tb_pwm_deadtime_gen;
  localparam int CH = 3;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pwm_deadtime_gen_if #(.CHANNELS(CH), .DT_WIDTH(DW)) bus ();

  pwm_deadtime_gen #(.CHANNELS(CH), .DT_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: which side conducts (0 none, 1 A, 2 B), which side is awaited during a gap,
  // and how many more edges of gap remain.
  int         m_on   [CH];
  int         m_pend [CH];
  int         m_left [CH];
  logic [CH-1:0] m_pwm_r;
  logic          m_fault;

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      m_on[n]   = 0;
      m_pend[n] = 0;
      m_left[n] = 0;
    end
    m_pwm_r = '0;
    m_fault = 1'b0;
  endtask

  task automatic model_edge();
    int want;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int n = 0; n < CH; n++) begin
      want = m_pwm_r[n] ? 1 : 2;
      d    = int'(bus.deadtime[n*DW +: DW]);
      if (m_fault || bus.fault || !bus.enable[n]) begin
        m_on[n]   = 0;
        m_pend[n] = 0;
        m_left[n] = 0;
      end else if (m_pend[n] != 0) begin
        if (want != m_pend[n]) begin
          m_on[n]   = want;
          m_pend[n] = 0;
        end else begin
          m_left[n] = m_left[n] - 1;
          if (m_left[n] == 0) begin
            m_on[n]   = m_pend[n];
            m_pend[n] = 0;
          end
        end
      end else if (m_on[n] != want) begin
        m_on[n] = 0;
        if (d == 0) m_on[n] = want;
        else begin
          m_pend[n] = want;
          m_left[n] = d;
        end
      end
    end
    m_pwm_r = bus.pwm;
    m_fault = bus.fault | (m_fault & ~bus.fault_clr);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [CH-1:0] ea;
    logic [CH-1:0] eb;
    logic [CH-1:0] ed;
    for (int n = 0; n < CH; n++) begin
      ea[n] = (m_on[n] == 1);
      eb[n] = (m_on[n] == 2);
      ed[n] = (m_pend[n] != 0);
    end
    chk("pwm_a", 32'(bus.pwm_a), 32'(ea));
    chk("pwm_b", 32'(bus.pwm_b), 32'(eb));
    chk("dt_active", 32'(bus.dt_active), 32'(ed));
    chk("fault_flag", 32'(bus.fault_flag), 32'(m_fault));
    chk("a_and_b", 32'(bus.pwm_a & bus.pwm_b), 32'(0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_dt(input int n, input int d);
    bus.deadtime[n*DW +: DW] = DW'(d);
  endtask

  task automatic run_count(input int ch, input int cycles, output int n_dt, output int n_alow,
                           output int n_b, output int n_off);
    n_dt = 0; n_alow = 0; n_b = 0; n_off = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.dt_active[ch]) n_dt++;
      if (!bus.pwm_a[ch]) n_alow++;
      if (bus.pwm_b[ch]) n_b++;
      if (!bus.pwm_a[ch] && !bus.pwm_b[ch]) n_off++;
    end
  endtask

  // Returns the step index at which the chosen side first rises, 0 if the bound expires.
  task automatic wait_rise(input int ch, input logic side_a, input int limit, output int k,
                           output int n_dt);
    k = 0; n_dt = 0;
    for (int i = 1; i <= limit && k == 0; i++) begin
      step();
      if (bus.dt_active[ch]) n_dt++;
      if (side_a ? bus.pwm_a[ch] : bus.pwm_b[ch]) k = i;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int k, n_dt, n_alow, n_b, n_off, acc;
    bus.pwm = '0; bus.enable = '0; bus.deadtime = '0; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;

    // Start-up with D=4 on ch0, then a hand-over to B.
    set_dt(0, 4);
    bus.pwm[0] = 1'b1;
    repeat (2) step();
    bus.enable = 3'b001;
    wait_rise(0, 1'b1, 20, k, n_dt);
    chk("t1_startup_rise", 32'(k), 32'd5);
    run_count(0, 20, n_dt, n_alow, n_b, n_off);
    bus.pwm[0] = 1'b0;
    wait_rise(0, 1'b0, 20, k, n_dt);
    chk("t1_b_rise", 32'(k), 32'd6);
    chk("t1_dt_cycles", 32'(n_dt), 32'd4);

    // D=0 on ch1: direct swap, no both-low cycle.
    set_dt(1, 0);
    bus.pwm[1] = 1'b1;
    bus.enable[1] = 1'b1;
    repeat (2) step();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.pwm[1] = ~bus.pwm[1];
      run_count(1, 3, n_dt, n_alow, n_b, n_off);
      acc += n_off;
    end
    chk("t2_no_gap", 32'(acc), 32'd0);

    // D=8 on ch2: a 3-cycle low pulse is swallowed.
    set_dt(2, 8);
    bus.pwm[2] = 1'b1;
    bus.enable[2] = 1'b1;
    run_count(2, 12, n_dt, n_alow, n_b, n_off);
    bus.pwm[2] = 1'b0;
    run_count(2, 3, n_dt, n_alow, n_b, n_off);
    acc = n_alow;
    k = n_b;
    bus.pwm[2] = 1'b1;
    run_count(2, 12, n_dt, n_alow, n_b, n_off);
    chk("t3_a_low", 32'(acc + n_alow), 32'd3);
    chk("t3_b_never", 32'(k + n_b), 32'd0);

    // Dead-time changed mid-count keeps the sampled value.
    set_dt(0, 6);
    bus.pwm[0] = 1'b1;
    run_count(0, 3, n_dt, n_alow, n_b, n_off);
    acc = n_dt;
    set_dt(0, 2);
    run_count(0, 10, n_dt, n_alow, n_b, n_off);
    chk("t4_dt_old", 32'(acc + n_dt), 32'd6);
    bus.pwm[0] = 1'b0;
    run_count(0, 10, n_dt, n_alow, n_b, n_off);
    chk("t4_dt_new", 32'(n_dt), 32'd2);

    // Fault during B_ON on all channels, then clear and restart.
    for (int n = 0; n < CH; n++) set_dt(n, 3);
    bus.pwm = '0;
    bus.enable = '1;
    run_count(0, 12, n_dt, n_alow, n_b, n_off);
    chk("t5_all_b", 32'(bus.pwm_b), 32'd7);
    bus.fault = 1'b1;
    step();
    chk("t5_fault_off", 32'(bus.pwm_a | bus.pwm_b), 32'd0);
    chk("t5_flag_set", 32'(bus.fault_flag), 32'd1);
    bus.fault = 1'b0;
    run_count(0, 4, n_dt, n_alow, n_b, n_off);
    chk("t5_flag_sticky", 32'(bus.fault_flag), 32'd1);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk("t5_flag_clr", 32'(bus.fault_flag), 32'd0);
    wait_rise(0, 1'b0, 20, k, n_dt);
    chk("t5_restart", 32'(k), 32'd4);

    // Asynchronous reset mid-pulse.
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_a", 32'(bus.pwm_a), 32'd0);
    chk("t6_async_b", 32'(bus.pwm_b), 32'd0);
    model_reset();
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    run_count(0, 6, n_dt, n_alow, n_b, n_off);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int n = 0; n < CH; n++) begin
        if ($urandom_range(0, 5) == 0) bus.pwm[n] = ~bus.pwm[n];
        if ($urandom_range(0, 19) == 0) set_dt(n, int'($urandom_range(0, 6)));
        if ($urandom_range(0, 59) == 0) bus.enable[n] = ~bus.enable[n];
      end
      bus.fault     = ($urandom_range(0, 79) == 0);
      bus.fault_clr = ($urandom_range(0, 14) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
